// File: rtl/serial_adder_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | serial_adder_pkg : shared state encoding and defaults for serial_adder |
// | Revision 1.0                                                           |
// +----------------------------------------------------------------------+
package serial_adder_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage
`default_nettype wire

// File: rtl/serial_adder_fa_cell.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fa_cell : 1-bit combinational full adder                              |
// | Revision 1.0                                                           |
// +----------------------------------------------------------------------+
module fa_cell (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);

endmodule
`default_nettype wire

// File: rtl/serial_adder.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | serial_adder : LSB-first bit-serial adder, start/busy/done handshake  |
// | Optional subtract mode via SERIAL_ADDER_SUB_EN. Revision 1.0           |
// +----------------------------------------------------------------------+
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             sub,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [WIDTH-1:0]   sum_q, sum_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               carry_q, carry_d;
  logic               cout_q, cout_d;

  logic               fa_sum;
  logic               fa_cout;
  logic [WIDTH-1:0]   b_load;
  logic               carry_load;

  fa_cell u_fa (
    .a    (a_q[0]),
    .b    (b_q[0]),
    .cin  (carry_q),
    .sum  (fa_sum),
    .cout (fa_cout)
  );

  // Subtraction is a + ~b + 1, so the carry-in is forced and cout means "no borrow".
`ifdef SERIAL_ADDER_SUB_EN
  assign b_load     = sub ? ~b : b;
  assign carry_load = sub ? 1'b1 : cin;
`else
  assign b_load     = b;
  assign carry_load = cin;
`endif

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    cout_d  = cout_q;

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          a_d     = a;
          b_d     = b_load;
          carry_d = carry_load;
          cnt_d   = '0;
          state_d = RUN;
        end else if (state_q == DONE) begin
          state_d = IDLE;
        end
      end

      RUN: begin
        sum_d   = {fa_sum, sum_q[WIDTH-1:1]};
        a_d     = a_q >> 1;
        b_d     = b_q >> 1;
        carry_d = fa_cout;
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == LAST_BIT) begin
          cout_d  = fa_cout;
          state_d = DONE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
    end
  end

  assign busy = (state_q == RUN);
  assign done = (state_q == DONE);
  assign sum  = sum_q;
  assign cout = cout_q;

endmodule
`default_nettype wire

// File: tb/tb_serial_adder.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_serial_adder : self-checking bench for serial_adder (WIDTH=8)      |
// | Revision 1.0                                                           |
// +----------------------------------------------------------------------+
module tb_serial_adder;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         cin = 1'b0;
  logic         sub = 1'b0;
  logic         busy, done, cout;
  logic [W-1:0] sum;

  int total = 0;
  int bad = 0;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         sub;
    logic [W-1:0] s;
    logic         co;
  } vec_t;

  vec_t vq[$];

  serial_adder #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
`ifdef SERIAL_ADDER_SUB_EN
    .sub   (sub),
`endif
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Plain integer arithmetic reference: {cout, sum}.
  function automatic logic [W:0] model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                       input logic mc, input logic ms);
    int unsigned r;
    if (ms) begin
      r = (int'(ma) - int'(mb)) & ((1 << W) - 1);
      return {(ma >= mb), r[W-1:0]};
    end
    r = int'(ma) + int'(mb) + int'(mc);
    return r[W:0];
  endfunction

  // One transaction; poke re-asserts start with other operands during RUN.
  task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_, input logic tc,
                        input logic ts, input logic [W-1:0] es, input logic ec,
                        input bit poke, input string nm);
    int n;
    int nb;
    @(negedge clk);
    a = ta; b = tb_; cin = tc; sub = ts; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    a = ~ta; b = ~tb_; cin = ~tc;
    n = 0; nb = 0;
    while (!done && n < 4 * W) begin
      if (busy) nb++;
      start = (poke && n >= 3 && n <= 5);
      @(negedge clk);
      n++;
    end
    start = 1'b0;
    chk({nm, "_latency"}, n, W);
    chk({nm, "_busy_cycles"}, nb, W);
    chk({nm, "_busy_with_done"}, busy, 0);
    chk({nm, "_sum"}, sum, es);
    chk({nm, "_cout"}, cout, ec);
    @(negedge clk);
    chk({nm, "_done_pulse"}, {busy, done}, 2'b00);
    chk({nm, "_sum_hold"}, sum, es);
  endtask

  initial begin
    logic [W:0] m;
    int dq[$];
    int n;

    #2;
    chk("reset_outputs", {busy, done, sum, cout}, '0);
    @(negedge clk);
    rst = 1'b0;

    vq.push_back('{8'h5A, 8'h33, 1'b0, 1'b0, 8'h8D, 1'b0});
    vq.push_back('{8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1});
    vq.push_back('{8'hFF, 8'h00, 1'b1, 1'b0, 8'h00, 1'b1});
    vq.push_back('{8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0});
    vq.push_back('{8'h7F, 8'h01, 1'b1, 1'b0, 8'h81, 1'b0});
    vq.push_back('{8'h80, 8'h80, 1'b0, 1'b0, 8'h00, 1'b1});
`ifdef SERIAL_ADDER_SUB_EN
    vq.push_back('{8'h10, 8'h01, 1'b0, 1'b1, 8'h0F, 1'b1});
    vq.push_back('{8'h00, 8'h01, 1'b0, 1'b1, 8'hFF, 1'b0});
    vq.push_back('{8'h00, 8'h01, 1'b1, 1'b1, 8'hFF, 1'b0});
`endif
    foreach (vq[i])
      run_op(vq[i].a, vq[i].b, vq[i].cin, vq[i].sub, vq[i].s, vq[i].co, 1'b0,
             $sformatf("vec%0d", i));

    // start during RUN must not disturb the result in flight
    run_op(8'h5A, 8'h33, 1'b0, 1'b0, 8'h8D, 1'b0, 1'b1, "ignore_start");

    for (int i = 0; i < 16; i++) begin
      logic [W-1:0] ra, rb;
      logic rc, rs;
      ra = W'($urandom); rb = W'($urandom);
      rc = 1'($urandom); rs = 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
      rs = 1'($urandom);
`endif
      m = model(ra, rb, rc, rs);
      run_op(ra, rb, rc, rs, m[W-1:0], m[W], 1'b0, $sformatf("rand%0d", i));
    end

    // Back-to-back: start held high
    @(negedge clk);
    a = 8'h01; b = 8'h02; cin = 1'b0; sub = 1'b0; start = 1'b1;
    @(negedge clk);
    for (n = 0; n < 3 * (W + 1); n++) begin
      if (busy && done) chk("b2b_busy_with_done", 1, 0);
      if (done) begin
        dq.push_back(n);
        chk("b2b_sum", sum, 8'h03);
        chk("b2b_cout", cout, 0);
      end
      @(negedge clk);
    end
    start = 1'b0;
    chk("b2b_count", dq.size(), 3);
    if (dq.size() >= 3) begin
      chk("b2b_first", dq[0], W);
      chk("b2b_spacing1", dq[1] - dq[0], W + 1);
      chk("b2b_spacing2", dq[2] - dq[1], W + 1);
    end
    repeat (2 * W) @(negedge clk);

    // Asynchronous reset in the middle of RUN
    a = 8'hFF; b = 8'hFF; cin = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    chk("midrst_busy_before", busy, 1);
    #2 rst = 1'b1;
    #1;
    chk("midrst_outputs", {busy, done, sum, cout}, '0);
    @(negedge clk);
    rst = 1'b0;
    run_op(8'h5A, 8'h33, 1'b0, 1'b0, 8'h8D, 1'b0, 1'b0, "after_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got timeout expected finish");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire

// File: doc/serial_adder.md
# serial_adder

Parametrised bit-serial adder built from one full-adder cell and a carry flip-flop. Adds two WIDTH-bit operands LSB-first, one bit per clock, behind a start/busy/done handshake. Sits beside the combinational full-adder library as the area-minimal multi-bit adder for slow datapaths; optional subtract mode.

## Interface
- WIDTH, 8, operand/result width in bits; legal range 2..64
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous reset, active-high
- start  input  1  request; sampled only in IDLE or DONE
- a  input  WIDTH  operand A, captured on the accepting edge
- b  input  WIDTH  operand B, captured on the accepting edge
- cin  input  1  carry-in, captured on the accepting edge
- sub  input  1  subtract request; port exists only when SERIAL_ADDER_SUB_EN is defined
- busy  output  1  high while bits are being processed
- done  output  1  one-cycle pulse when sum/cout become valid
- sum  output  WIDTH  result; holds until the next accepted start
- cout  output  1  final carry-out; holds with sum

## Operation
- States: IDLE, RUN, DONE.
- IDLE: start=1 → latch a, b and cin into the A/B shift registers and the carry FF; clear the bit counter; go to RUN.
- RUN: each cycle, add A[0] + B[0] + carry in the full-adder cell. Shift the sum bit into the MSB of the result shift register. Shift A and B right. Update carry. Increment the counter. After bit WIDTH-1 → DONE.
- DONE: done=1 for one cycle; sum/cout valid. start=1 here is accepted exactly as in IDLE and goes to RUN. Otherwise go to IDLE.
- start in RUN is ignored. Operands are not re-sampled.
- sum/cout change only during RUN. Intermediate values in RUN are partial and not valid.
- Counter width is $clog2(WIDTH). Carry is 1 bit. No overflow flag.
- Reset, including mid-operation: state=IDLE, busy=0, done=0, sum=0, cout=0, counter=0, carry=0. Asynchronous assertion; all state is cleared.

## Timing
- Accepting edge = edge 0.
- busy is high in the cycles after edges 0..WIDTH-1 (WIDTH cycles).
- The edge WIDTH transition makes done=1 and busy=0 for one cycle; sum/cout are valid from then on.
- Latency start→done = WIDTH+1 cycles.
- Back-to-back: start held high in the DONE cycle gives a throughput of one result per WIDTH+1 cycles.
- busy and done are never high together.

## Configuration
- SERIAL_ADDER_SUB_EN defined:
  - The sub port exists and is captured with the operands.
  - sub=1 loads ~b into the B register and forces the carry FF to 1 (cin ignored).
  - cout=1 means no borrow.
- SERIAL_ADDER_SUB_EN undefined:
  - No sub port.
  - The block is add-only.

## Structure
- Shared package/header holds:
  - State encoding constants: IDLE=2'd0, RUN=2'd1, DONE=2'd2.
  - Default WIDTH constant.
- Sub-module fa_cell: the 1-bit combinational full adder (sum, cout, a, b, cin) used for the per-bit addition.
- All registers, the counter and the FSM live in serial_adder.

## Test plan
- WIDTH=8: a=0x5A, b=0x33, cin=0, start pulse → done exactly 9 cycles later; sum=0x8D, cout=0; busy high 8 cycles.
- a=0xFF, b=0x01, cin=0 → sum=0x00, cout=1. Then a=0xFF, b=0x00, cin=1 → sum=0x00, cout=1.
- start re-asserted in cycles 3–5 of RUN with different operands → ignored; the original result is returned at the original done cycle.
- start held high continuously with a=0x01, b=0x02 → results 0x03 every 9 cycles; done pulses one cycle each; busy never coincides with done.
- rst asserted at RUN cycle 4 → busy, done, sum and cout go to 0 immediately. A start after release gives a correct fresh result.
- SERIAL_ADDER_SUB_EN: sub=1, a=0x10, b=0x01 → sum=0x0F, cout=1. sub=1, a=0x00, b=0x01 → sum=0xFF, cout=0.
